// File: rtl/cpu_halt_ctrl_if.sv
// cpu_halt_ctrl_if: DMA request, CPU halt and NMI signal bundle between the requester side and the controller.
interface cpu_halt_ctrl_if;
    logic       dma_req;
    logic [3:0] dma_len;
    logic       RW;
    logic       nmi_evt;
    logic       nmi_en;
    logic       nmi_clr;
    logic       RDY;
    logic       dma_gnt;
    logic       nmi;
    logic       nmi_st;
    logic       halt_err;
    modport master (output dma_req, dma_len, RW, nmi_evt, nmi_en, nmi_clr,
                    input  RDY, dma_gnt, nmi, nmi_st, halt_err);
    modport slave  (input  dma_req, dma_len, RW, nmi_evt, nmi_en, nmi_clr,
                    output RDY, dma_gnt, nmi, nmi_st, halt_err);
endinterface

// File: rtl/cpu_halt_ctrl.sv
// cpu_halt_ctrl: halts the CPU on a read cycle to hand the bus to a DMA burst, with a halt watchdog
// and an independent NMI edge detector / two-cycle pulse generator. All outputs are registered.
module cpu_halt_ctrl #(
    parameter int WDOG_MAX = 7
) (
    input logic           phi2,
    input logic           rst,
    cpu_halt_ctrl_if.slave bus
);
    localparam int WW = (WDOG_MAX < 1) ? 1 : $clog2(WDOG_MAX + 1);
    localparam logic [WW-1:0] WD_SAT = WDOG_MAX[WW-1:0];
    typedef enum logic [1:0] {IDLE, HALT, GRANT, REL} state_t;
    state_t        r_state, w_next;
    logic [3:0]    r_cnt, w_cnt;
    logic [WW-1:0] r_wd, w_wd;
    logic          r_rdy, r_gnt, r_err;
    logic          r_evt, r_nmi, r_st;
    logic [1:0]    r_pcnt, w_pcnt;
    logic          w_rise, w_fire;
    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_wd   = r_wd;
        case (r_state)
            IDLE:
                if (bus.dma_req) begin
                    w_next = HALT;
                    w_cnt  = bus.dma_len;
                    w_wd   = '0;
                end
            HALT:
                if (!bus.dma_req) w_next = IDLE;
                else if (bus.RW) w_next = GRANT;
                else if (r_wd != WD_SAT) w_wd = r_wd + 1'b1;
            GRANT:
                if (r_cnt == 4'd0) w_next = REL;
                else w_cnt = r_cnt - 4'd1;
            REL:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // A new NMI pulse only starts once the previous one has fully drained.
    assign w_rise = bus.nmi_evt & ~r_evt;
    assign w_fire = w_rise & bus.nmi_en & (r_pcnt == 2'd0);
    assign w_pcnt = w_fire ? 2'd2 : (r_pcnt != 2'd0) ? r_pcnt - 2'd1 : 2'd0;
    always_ff @(posedge phi2 or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_rdy   <= 1'b1;
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
            r_evt   <= 1'b0;
            r_pcnt  <= '0;
            r_nmi   <= 1'b0;
            r_st    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            r_wd    <= w_wd;
            r_rdy   <= (w_next == IDLE) || (w_next == REL);
            r_gnt   <= (w_next == GRANT);
            r_err   <= r_err | ((r_state == HALT) && (w_wd == WD_SAT));
            r_evt   <= bus.nmi_evt;
            r_pcnt  <= w_pcnt;
            r_nmi   <= (w_pcnt != 2'd0);
            r_st    <= w_rise | (r_st & ~bus.nmi_clr);
        end
    end
    assign bus.RDY      = r_rdy;
    assign bus.dma_gnt  = r_gnt;
    assign bus.nmi      = r_nmi;
    assign bus.nmi_st   = r_st;
    assign bus.halt_err = r_err;
endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// tb_cpu_halt_ctrl: directed and random stimulus against a transaction-level model of bursts and NMI pulses.
module tb_cpu_halt_ctrl;
    localparam int WDOG = 7;
    logic phi2 = 1'b0;
    logic rst  = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int m_halt, m_left, m_rel, m_len, m_streak, m_err, m_prev, m_st, m_pl;
    int gnt_cnt, rdy_lo, nmi_cnt;
    always #5 phi2 = ~phi2;
    cpu_halt_ctrl_if bus();
    cpu_halt_ctrl #(.WDOG_MAX(WDOG)) dut (.phi2(phi2), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        {m_halt, m_left, m_rel, m_len, m_streak, m_err, m_prev, m_st, m_pl} = '0;
    endtask
    // Burst seen as: requested -> waiting for a read -> (len+1) grant cycles -> one release cycle.
    task automatic step();
        bit rise;
        rise = bus.nmi_evt && !m_prev;
        m_prev = bus.nmi_evt;
        m_st = rise || (m_st != 0 && !bus.nmi_clr);
        if (m_pl > 0) m_pl--;
        else if (rise && bus.nmi_en) m_pl = 2;
        if (m_rel != 0) m_rel = 0;
        else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_rel = 1;
        end else if (m_halt != 0) begin
            if (!bus.dma_req) m_halt = 0;
            else if (bus.RW) begin
                m_halt = 0;
                m_left = m_len + 1;
            end else begin
                if (m_streak < WDOG) m_streak++;
                if (m_streak == WDOG) m_err = 1;
            end
        end else if (bus.dma_req) begin
            m_halt = 1;
            m_len = bus.dma_len;
            m_streak = 0;
        end
    endtask
    task automatic check_all();
        chk("RDY", bus.RDY, (m_halt == 0 && m_left == 0) ? 1 : 0);
        chk("dma_gnt", bus.dma_gnt, m_left > 0 ? 1 : 0);
        chk("nmi", bus.nmi, m_pl > 0 ? 1 : 0);
        chk("nmi_st", bus.nmi_st, m_st);
        chk("halt_err", bus.halt_err, m_err);
        gnt_cnt += bus.dma_gnt;
        rdy_lo  += !bus.RDY;
        nmi_cnt += bus.nmi;
    endtask
    task automatic drive(input bit req, input bit [3:0] len, input bit rw, input bit evt, input bit en, input bit clr);
        bus.dma_req = req;
        bus.dma_len = len;
        bus.RW      = rw;
        bus.nmi_evt = evt;
        bus.nmi_en  = en;
        bus.nmi_clr = clr;
    endtask
    task automatic cyc(input bit req, input bit [3:0] len, input bit rw, input bit evt, input bit en, input bit clr);
        @(negedge phi2);
        check_all();
        drive(req, len, rw, evt, en, clr);
        @(posedge phi2);
        step();
    endtask
    task automatic reset_chk(input string tag);
        chk({tag, "_RDY"}, bus.RDY, 1);
        chk({tag, "_gnt"}, bus.dma_gnt, 0);
        chk({tag, "_nmi"}, bus.nmi, 0);
        chk({tag, "_st"}, bus.nmi_st, 0);
        chk({tag, "_err"}, bus.halt_err, 0);
    endtask
    task automatic do_reset(input bit evt);
        @(negedge phi2);
        rst = 1'b0;
        drive(0, 0, 0, evt, 0, 0);
        model_reset();
        #1 reset_chk("rst");
        @(negedge phi2);
        rst = 1'b1;
        @(posedge phi2);
        step();
        gnt_cnt = 0;
        rdy_lo  = 0;
        nmi_cnt = 0;
    endtask
    initial begin
        bit evt;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        do_reset(0);
        cyc(1, 3, 1, 0, 0, 0);
        cyc(1, 9, 1, 0, 0, 0);
        repeat (8) cyc(0, 9, 0, 0, 0, 0);
        chk("burst4_gnt", gnt_cnt, 4);
        chk("burst4_rdylo", rdy_lo, 5);
        gnt_cnt = 0; rdy_lo = 0;
        cyc(1, 0, 0, 0, 0, 0);
        repeat (3) cyc(1, 5, 0, 0, 0, 0);
        cyc(1, 5, 1, 0, 0, 0);
        repeat (4) cyc(0, 5, 0, 0, 0, 0);
        chk("wait3_gnt", gnt_cnt, 1);
        chk("wait3_rdylo", rdy_lo, 5);
        chk("wait3_err", bus.halt_err, 0);
        gnt_cnt = 0;
        cyc(1, 1, 0, 0, 0, 0);
        repeat (8) cyc(1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0, 0);
        chk("wdog_err", bus.halt_err, 1);
        chk("wdog_gnt", gnt_cnt, 2);
        do_reset(0);
        cyc(1, 2, 0, 0, 0, 0);
        cyc(0, 2, 1, 0, 0, 0);
        repeat (4) cyc(0, 2, 1, 0, 0, 0);
        chk("abort_gnt", gnt_cnt, 0);
        repeat (12) cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        nmi_cnt = 0;
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        repeat (4) cyc(0, 0, 0, 1, 1, 0);
        chk("nmi_len", nmi_cnt, 2);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("nmi_set_wins", bus.nmi_st, 1);
        do_reset(1);
        cyc(0, 0, 0, 1, 0, 0);
        chk("evt_at_release", bus.nmi_st, 1);
        cyc(1, 7, 1, 0, 0, 0);
        cyc(1, 7, 1, 1, 1, 0);
        @(negedge phi2);
        check_all();
        chk("pre_rst_gnt", bus.dma_gnt, 1);
        chk("pre_rst_nmi", bus.nmi, 1);
        #2 rst = 1'b0;
        #1 reset_chk("async");
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge phi2);
        rst = 1'b1;
        @(posedge phi2);
        step();
        repeat (3) cyc(0, 0, 0, 0, 0, 0);
        for (int b = 0; b < 5; b++) begin
            do_reset($urandom_range(0, 1) == 1);
            evt = 0;
            for (int i = 0; i < 250; i++) begin
                if ($urandom_range(0, 3) == 0) evt = ~evt;
                cyc($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0,
                    evt, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
            end
        end
        @(negedge phi2);
        check_all();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
